// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Command-issue and result-capture stage for an external
//             combinational 8-bit ALU. Commands are queued in a DEPTH-entry
//             FIFO, issued from a registered stage (S1) that drives the ALU
//             inputs, and the ALU result/flags are captured one cycle later
//             into a result stage (S2). Valid/ready handshakes on both sides.
//  Config   : `define ALU_ISSUE_ACC_EN to add an accumulator that can replace
//             operand a (selected per command with in_use_acc), with
//             forwarding from the in-flight operation.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             in_valid/in_ready          - command handshake
//             in_a, in_b, in_ctrl        - operands and opcode
//             in_use_acc                 - use accumulator as operand a
//             alu_a, alu_b, alu_ctrl     - registered ALU inputs (S1)
//             alu_y, alu_zero/negative/carry - ALU result and flags
//             out_valid/out_ready        - result handshake
//             out_y, out_ctrl, out_zero/negative/carry - captured result (S2)
//             count                      - FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [2:0]               in_ctrl,
    input  logic                     in_use_acc,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_ctrl,
    input  logic [7:0]               alu_y,
    input  logic                     alu_zero,
    input  logic                     alu_negative,
    input  logic                     alu_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_y,
    output logic [2:0]               out_ctrl,
    output logic                     out_zero,
    output logic                     out_negative,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]    mem_a_q    [DEPTH];
    logic [7:0]    mem_b_q    [DEPTH];
    logic [2:0]    mem_ctrl_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [7:0]    alu_a_q,    alu_a_d;
    logic [7:0]    alu_b_q,    alu_b_d;
    logic [2:0]    alu_ctrl_q, alu_ctrl_d;
    logic          s1_valid_q, s1_valid_d;

    logic [7:0]    out_y_q,    out_y_d;
    logic [2:0]    out_ctrl_q, out_ctrl_d;
    logic          out_zero_q, out_zero_d;
    logic          out_neg_q,  out_neg_d;
    logic          out_carry_q, out_carry_d;
    logic          out_valid_q, out_valid_d;

`ifdef ALU_ISSUE_ACC_EN
    logic          mem_acc_q  [DEPTH];
    logic [7:0]    acc_q, acc_d;
`else
    // in_use_acc has no function without the accumulator.
    logic          unused_use_acc;
    assign unused_use_acc = in_use_acc;
`endif

    // ------------------------------------------------------------------
    // Handshake / advance conditions
    // ------------------------------------------------------------------
    logic push, pop, s1_adv, s2_adv, fifo_nonempty;

    assign in_ready      = (count_q != C_FULL);
    assign fifo_nonempty = (count_q != '0);
    assign push          = in_valid && in_ready;
    assign s2_adv        = s1_valid_q && (!out_valid_q || out_ready);
    assign s1_adv        = !s1_valid_q || s2_adv;
    // Pop is allowed while full; in_ready is already low that cycle, so a
    // full FIFO never sees a simultaneous push.
    assign pop           = s1_adv && fifo_nonempty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        s1_valid_d  = s1_valid_q;
        out_y_d     = out_y_q;
        out_ctrl_d  = out_ctrl_q;
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;
        out_carry_d = out_carry_q;
        out_valid_d = out_valid_q;
`ifdef ALU_ISSUE_ACC_EN
        acc_d       = acc_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // S1: issue stage. Operands are held when the FIFO runs dry so the
        // ALU inputs stay stable; only the valid bit drops.
        if (s1_adv) begin
            if (fifo_nonempty) begin
                alu_a_d    = mem_a_q[rd_ptr_q];
                alu_b_d    = mem_b_q[rd_ptr_q];
                alu_ctrl_d = mem_ctrl_q[rd_ptr_q];
                s1_valid_d = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
                // If an op is in S1 it is moving to S2 this edge (pop with
                // s1_valid implies s2_adv), so its live ALU result is the
                // value the accumulator is about to take.
                if (mem_acc_q[rd_ptr_q]) begin
                    alu_a_d = s1_valid_q ? alu_y : acc_q;
                end
`endif
            end else begin
                s1_valid_d = 1'b0;
            end
        end

        // S2: result capture.
        if (s2_adv) begin
            out_y_d     = alu_y;
            out_ctrl_d  = alu_ctrl_q;
            out_zero_d  = alu_zero;
            out_neg_d   = alu_negative;
            out_carry_d = alu_carry;
            out_valid_d = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
            acc_d       = alu_y;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO payload storage (no reset needed; guarded by pointers/count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]    <= in_a;
            mem_b_q[wr_ptr_q]    <= in_b;
            mem_ctrl_q[wr_ptr_q] <= in_ctrl;
`ifdef ALU_ISSUE_ACC_EN
            mem_acc_q[wr_ptr_q]  <= in_use_acc;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Control and pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= 3'b000;
            s1_valid_q  <= 1'b0;
            out_y_q     <= '0;
            out_ctrl_q  <= 3'b000;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
            out_carry_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_ISSUE_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            s1_valid_q  <= s1_valid_d;
            out_y_q     <= out_y_d;
            out_ctrl_q  <= out_ctrl_d;
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
            out_carry_q <= out_carry_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_ISSUE_ACC_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign out_valid    = out_valid_q;
    assign out_y        = out_y_q;
    assign out_ctrl     = out_ctrl_q;
    assign out_zero     = out_zero_q;
    assign out_negative = out_neg_q;
    assign out_carry    = out_carry_q;
    assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Self-checking bench for alu_issue with a stand-in ALU model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_ctrl;
    logic       in_use_acc;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_y;
    logic       alu_zero, alu_negative, alu_carry;
    logic       out_valid, out_ready;
    logic [7:0] out_y;
    logic [2:0] out_ctrl;
    logic       out_zero, out_negative, out_carry;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_ctrl      (in_ctrl),
        .in_use_acc   (in_use_acc),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_ctrl     (out_ctrl),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .out_carry    (out_carry),
        .count        (count)
    );

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_y        = 8'h00;
        alu_zero     = 1'b0;
        alu_negative = 1'b0;
        alu_carry    = 1'b0;
        case (alu_ctrl)
            3'b000: alu_y = alu_a & alu_b;
            3'b001: alu_y = alu_a | alu_b;
            3'b010: begin
                {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_zero     = (alu_y == 8'h00);
                alu_negative = alu_y[7];
            end
            3'b110: begin
                {alu_carry, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
                alu_zero     = (alu_y == 8'h00);
                alu_negative = alu_y[7];
            end
            default: alu_y = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] c, input logic acc);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_ctrl    = c;
        in_use_acc = acc;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] ctrl;
        logic [7:0] y;
        logic       z;
        logic       n;
        logic       c;
    } vec_t;

    vec_t vecs[9];
    int   accepted;
    logic rdy_before;
    logic [7:0] exp_r1, exp_r2;

    initial begin
        vecs[0] = '{8'd200, 8'd100, 3'b010, 8'h2C, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'd5,   8'd10,  3'b110, 8'hFB, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'd7,   8'd7,   3'b110, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hF0,  8'h0F,  3'b000, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hAB,  8'hCD,  3'b111, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h5A,  8'h81,  3'b001, 8'hDB, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h7F,  8'h01,  3'b010, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h80,  8'h80,  3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'h03,  8'h04,  3'b011, 8'h00, 1'b0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        #12;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_a",     32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        chk("rst_out_y",     32'({out_y, out_ctrl, out_zero, out_negative, out_carry}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- single commands, empty pipe ----------------
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl, 1'b0);
            tick();                                  // accepted at edge k
            drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
            chk($sformatf("v%0d_valid_k", i), 32'(out_valid), 32'd0);
            tick();                                  // edge k+1: in S1
            chk($sformatf("v%0d_valid_k1", i), 32'(out_valid), 32'd0);
            tick();                                  // edge k+2: in S2
            chk($sformatf("v%0d_valid_k2", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_y", i),    32'(out_y),    32'(vecs[i].y));
            chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_flags", i),
                32'({out_zero, out_negative, out_carry}),
                32'({vecs[i].z, vecs[i].n, vecs[i].c}));
            tick();                                  // consumed
        end

        // ---------------- backpressure: DEPTH+2 = 6 held ----------------
        out_ready = 1'b0;
        accepted  = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive(1'b1, 8'(accepted), 8'd10, 3'b010, 1'b0);
            rdy_before = in_ready;
            tick();
            if (rdy_before) accepted++;
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        chk("bp_accepted",  32'(accepted),  32'd6);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_count",     32'(count),     32'd4);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_frozen_y",  32'(out_y),     32'd10);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_y", k),     32'(out_y),     32'(10 + k));
            if (k == 0) chk("drain_in_ready_before", 32'(in_ready), 32'd0);
            if (k == 1) chk("drain_in_ready_after",  32'(in_ready), 32'd1);
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        tick();

        // ---------------- accumulator / dependent chain ----------------
`ifdef ALU_ISSUE_ACC_EN
        exp_r1 = 8'd5;
        exp_r2 = 8'd4;
`else
        exp_r1 = 8'd23;
        exp_r2 = 8'd19;
`endif
        drive(1'b1, 8'd1,  8'd1, 3'b010, 1'b0); tick();
        drive(1'b1, 8'd20, 8'd3, 3'b010, 1'b1); tick();
        drive(1'b1, 8'd20, 8'd1, 3'b110, 1'b1); tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        chk("acc_r0_valid", 32'(out_valid), 32'd1);
        chk("acc_r0_y",     32'(out_y),     32'd2);
        tick();
        chk("acc_r1_valid", 32'(out_valid), 32'd1);
        chk("acc_r1_y",     32'(out_y),     32'(exp_r1));
        tick();
        chk("acc_r2_valid", 32'(out_valid), 32'd1);
        chk("acc_r2_y",     32'(out_y),     32'(exp_r2));
        tick();
        chk("acc_done", 32'(out_valid), 32'd0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i + 1), 8'd1, 3'b010, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        chk("pre_rst_count", 32'(count),     32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count),     32'd0);
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_out",      32'({out_y, out_ctrl, out_zero, out_negative, out_carry}), 32'd0);
        chk("mid_rst_alu",      32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", i), 32'(out_valid), 32'd0);
        end
        chk("post_rst_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
